// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared hall-call codes, button indices and lift direction constants
package lift_pkg;

    localparam int NUM_BTN = 6;

    localparam logic [2:0] REQ_NONE = 3'b000;
    localparam logic [2:0] REQ_1U   = 3'b001;
    localparam logic [2:0] REQ_2U   = 3'b010;
    localparam logic [2:0] REQ_3U   = 3'b011;
    localparam logic [2:0] REQ_2D   = 3'b110;
    localparam logic [2:0] REQ_3D   = 3'b111;
    localparam logic [2:0] REQ_4D   = 3'b100;

    localparam logic [2:0] BTN_1U = 3'd0;
    localparam logic [2:0] BTN_2U = 3'd1;
    localparam logic [2:0] BTN_3U = 3'd2;
    localparam logic [2:0] BTN_2D = 3'd3;
    localparam logic [2:0] BTN_3D = 3'd4;
    localparam logic [2:0] BTN_4D = 3'd5;

    localparam logic [1:0] STAY = 2'b00;
    localparam logic [1:0] UP   = 2'b01;
    localparam logic [1:0] DOWN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DISPATCH
    } sched_state_t;

    function automatic logic [2:0] code_of(input logic [2:0] idx);
        case (idx)
            BTN_1U:  return REQ_1U;
            BTN_2U:  return REQ_2U;
            BTN_3U:  return REQ_3U;
            BTN_2D:  return REQ_2D;
            BTN_3D:  return REQ_3D;
            BTN_4D:  return REQ_4D;
            default: return REQ_NONE;
        endcase
    endfunction

    function automatic logic [2:0] idx_of(input logic [2:0] code);
        case (code)
            REQ_1U:  return BTN_1U;
            REQ_2U:  return BTN_2U;
            REQ_3U:  return BTN_3U;
            REQ_2D:  return BTN_2D;
            REQ_3D:  return BTN_3D;
            REQ_4D:  return BTN_4D;
            default: return BTN_1U;
        endcase
    endfunction

endpackage

// File: rtl/lift_req_fifo.sv
// rtl/lift_req_fifo.sv - synchronous dispatch FIFO of 3-bit request codes
module lift_req_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [2:0]    push_data,
    input  logic          pop,
    output logic [2:0]    head,
    output logic [AW:0]   count
);

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr;
    logic [AW-1:0] rd;

    // Storage needs no reset: the head is only consumed while count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wr <= wr + 1'b1;
            end
            if (pop) begin
                rd <= rd + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd];

endmodule

// File: rtl/lift_req_scheduler.sv
// rtl/lift_req_scheduler.sv - hall-call capture, round-robin enqueue and lift dispatch; LIFT_REQ_SCHED_STATS_EN adds dispatch statistics
module lift_req_scheduler
    import lift_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  btn,
    input  logic        lift_done,
    output logic [2:0]  req_code,
    output logic        q_empty,
    output logic [5:0]  lamp,
    output logic [5:0]  served
`ifdef LIFT_REQ_SCHED_STATS_EN
    ,
    output logic [15:0] stat_dispatched,
    output logic [7:0]  stat_maxwait
`endif
);

    logic [5:0]   pend;
    logic [5:0]   queued;
    logic [2:0]   rr;
    logic [5:0]   elig;
    logic         grant_found;
    logic [2:0]   grant_idx;
    logic [3:0]   scan;
    logic [5:0]   grant_mask;
    logic [5:0]   pop_mask;
    logic [5:0]   capture;
    logic         pop;
    logic [2:0]   head;
    logic [2:0]   head_idx;
    logic [AW:0]  count;
    sched_state_t state;
    sched_state_t state_next;

    assign lamp     = pend | queued;
    assign elig     = pend & ~queued;
    assign q_empty  = (count == '0);
    assign req_code = q_empty ? REQ_NONE : head;
    assign pop      = lift_done & ~q_empty;
    assign head_idx = idx_of(head);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int k = 0; k < NUM_BTN; k++) begin
            scan = {1'b0, rr} + 4'(k);
            if (scan >= 4'(NUM_BTN)) begin
                scan = scan - 4'(NUM_BTN);
            end
            if (!grant_found && elig[scan[2:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[2:0];
            end
        end
    end

    assign grant_mask = grant_found ? (6'b1 << grant_idx) : 6'b0;
    assign pop_mask   = pop ? (6'b1 << head_idx) : 6'b0;
    // A press on the call being popped this edge is accepted, so the call re-queues.
    assign capture    = btn & (~lamp | pop_mask);

    lift_req_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_found),
        .push_data (code_of(grant_idx)),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= '0;
            queued <= '0;
            rr     <= '0;
            served <= '0;
        end else begin
            pend   <= (pend & ~grant_mask) | capture;
            queued <= (queued & ~pop_mask) | grant_mask;
            served <= pop_mask;
            if (grant_found) begin
                rr <= (grant_idx == 3'd5) ? 3'd0 : grant_idx + 3'd1;
            end
        end
    end

    always_comb begin
        state_next = ST_IDLE;
        if (grant_found) begin
            state_next = ST_LOAD;
        end else if (!q_empty) begin
            state_next = ST_DISPATCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef LIFT_REQ_SCHED_STATS_EN
    logic [7:0] head_age;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_dispatched <= '0;
            stat_maxwait    <= '0;
            head_age        <= '0;
        end else if (pop) begin
            if (stat_dispatched != 16'hFFFF) begin
                stat_dispatched <= stat_dispatched + 16'd1;
            end
            if (head_age > stat_maxwait) begin
                stat_maxwait <= head_age;
            end
            head_age <= '0;
        end else if (!q_empty && head_age != 8'hFF) begin
            head_age <= head_age + 8'd1;
        end
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(grant_found && count == (AW+1)'(DEPTH)));

    a_idle_empty: assert property (@(posedge clk) disable iff (rst)
        (state == ST_IDLE) |-> q_empty);

endmodule

// File: tb/tb_lift_req_scheduler.sv
// tb/tb_lift_req_scheduler.sv - table vectors, directed reset sequence and random run against a queue model
module tb_lift_req_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] btn;
    logic       lift_done;
    logic [2:0] req_code;
    logic       q_empty;
    logic [5:0] lamp;
    logic [5:0] served;

    int vectors     = 0;
    int miscompares = 0;

    lift_req_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .lift_done (lift_done),
        .req_code  (req_code),
        .q_empty   (q_empty),
        .lamp      (lamp),
        .served    (served)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [5:0] b;
        logic       d;
        logic [2:0] req;
        logic       qe;
        logic [5:0] lamp;
        logic [5:0] served;
    } vec_t;

    vec_t tbl[$];

    logic [2:0] codes [6] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100};

    logic [5:0] m_pend;
    logic [5:0] m_queued;
    int         m_rr;
    logic [2:0] m_q[$];
    logic [2:0] m_req;
    logic       m_qe;
    logic [5:0] m_lamp;
    logic [5:0] m_served;

    function automatic void add(logic r, logic [5:0] b, logic d, logic [2:0] rq,
                                logic qe, logic [5:0] l, logic [5:0] s);
        vec_t v;
        v.r = r; v.b = b; v.d = d; v.req = rq; v.qe = qe; v.lamp = l; v.served = s;
        tbl.push_back(v);
    endfunction

    function automatic int code_to_idx(logic [2:0] c);
        for (int i = 0; i < 6; i++) begin
            if (codes[i] == c) return i;
        end
        return 0;
    endfunction

    task automatic check(input string name, input logic [2:0] er, input logic eqe,
                         input logic [5:0] el, input logic [5:0] es);
        vectors++;
        if (req_code !== er || q_empty !== eqe || lamp !== el || served !== es) begin
            miscompares++;
            $display("FAIL %s: got req=%b qe=%b lamp=%b served=%b, want req=%b qe=%b lamp=%b served=%b",
                     name, req_code, q_empty, lamp, served, er, eqe, el, es);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_queued = '0; m_rr = 0; m_q.delete();
        m_req = 3'b000; m_qe = 1'b1; m_lamp = '0; m_served = '0;
    endtask

    task automatic model_step(input logic [5:0] b, input logic d);
        logic [5:0] lamp_old;
        logic [5:0] np;
        logic [5:0] nq;
        int         g;
        int         h;
        bit         pop;
        lamp_old = m_pend | m_queued;
        np = m_pend;
        nq = m_queued;
        m_served = '0;
        h = -1;
        pop = d && (m_q.size() != 0);
        if (pop) begin
            h = code_to_idx(m_q[0]);
            nq[h] = 1'b0;
            m_served[h] = 1'b1;
            void'(m_q.pop_front());
        end
        g = -1;
        for (int k = 0; k < 6; k++) begin
            int j = (m_rr + k) % 6;
            if (g < 0 && m_pend[j] && !m_queued[j]) g = j;
        end
        if (g >= 0) begin
            m_q.push_back(codes[g]);
            nq[g] = 1'b1;
            np[g] = 1'b0;
            m_rr = (g + 1) % 6;
        end
        for (int i = 0; i < 6; i++) begin
            if (b[i] && (!lamp_old[i] || h == i)) np[i] = 1'b1;
        end
        m_pend = np;
        m_queued = nq;
        m_lamp = np | nq;
        m_qe = (m_q.size() == 0);
        m_req = m_qe ? 3'b000 : m_q[0];
    endtask

    task automatic drive(input logic [5:0] b, input logic d, input string name);
        @(negedge clk);
        btn = b;
        lift_done = d;
        model_step(b, d);
        @(posedge clk);
        #1;
        check(name, m_req, m_qe, m_lamp, m_served);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; btn = '0; lift_done = 1'b0;
        @(posedge clk);
        #1;
        check("reset", 3'b000, 1'b1, 6'b0, 6'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1; btn = '0; lift_done = 1'b0;

        add(1, 6'b000000, 0, 3'b000, 1, 6'b000000, 6'b000000);
        // single call, then an empty-queue done cycle
        add(0, 6'b000100, 0, 3'b000, 1, 6'b000100, 6'b000000);
        add(0, 6'b000000, 0, 3'b011, 0, 6'b000100, 6'b000000);
        add(0, 6'b000000, 1, 3'b000, 1, 6'b000000, 6'b000100);
        add(0, 6'b000000, 1, 3'b000, 1, 6'b000000, 6'b000000);
        // duplicate presses collapse to one entry
        add(0, 6'b000010, 0, 3'b000, 1, 6'b000010, 6'b000000);
        add(0, 6'b000000, 0, 3'b010, 0, 6'b000010, 6'b000000);
        add(0, 6'b000010, 0, 3'b010, 0, 6'b000010, 6'b000000);
        add(0, 6'b000000, 0, 3'b010, 0, 6'b000010, 6'b000000);
        add(0, 6'b000010, 0, 3'b010, 0, 6'b000010, 6'b000000);
        add(0, 6'b000000, 1, 3'b000, 1, 6'b000000, 6'b000010);
        // all six at once from rr=0
        add(1, 6'b000000, 0, 3'b000, 1, 6'b000000, 6'b000000);
        add(0, 6'b111111, 0, 3'b000, 1, 6'b111111, 6'b000000);
        for (int i = 0; i < 6; i++) add(0, 6'b000000, 0, 3'b001, 0, 6'b111111, 6'b000000);
        add(0, 6'b000000, 1, 3'b010, 0, 6'b111110, 6'b000001);
        add(0, 6'b000000, 1, 3'b011, 0, 6'b111100, 6'b000010);
        add(0, 6'b000000, 1, 3'b110, 0, 6'b111000, 6'b000100);
        add(0, 6'b000000, 1, 3'b111, 0, 6'b110000, 6'b001000);
        add(0, 6'b000000, 1, 3'b100, 0, 6'b100000, 6'b010000);
        add(0, 6'b000000, 1, 3'b000, 1, 6'b000000, 6'b100000);
        // round robin: rr=3 after granting 3U, then 3D wins over 1U
        add(0, 6'b000100, 0, 3'b000, 1, 6'b000100, 6'b000000);
        add(0, 6'b000000, 0, 3'b011, 0, 6'b000100, 6'b000000);
        add(0, 6'b010001, 0, 3'b011, 0, 6'b010101, 6'b000000);
        add(0, 6'b000000, 0, 3'b011, 0, 6'b010101, 6'b000000);
        add(0, 6'b000000, 0, 3'b011, 0, 6'b010101, 6'b000000);
        add(0, 6'b000000, 1, 3'b111, 0, 6'b010001, 6'b000100);
        add(0, 6'b000000, 1, 3'b001, 0, 6'b000001, 6'b010000);
        add(0, 6'b000000, 1, 3'b000, 1, 6'b000000, 6'b000001);
        // re-press 4D on the edge that pops it
        add(0, 6'b100000, 0, 3'b000, 1, 6'b100000, 6'b000000);
        add(0, 6'b000000, 0, 3'b100, 0, 6'b100000, 6'b000000);
        add(0, 6'b100000, 1, 3'b000, 1, 6'b100000, 6'b100000);
        add(0, 6'b000000, 0, 3'b100, 0, 6'b100000, 6'b000000);
        add(0, 6'b000000, 1, 3'b000, 1, 6'b000000, 6'b100000);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].r;
            btn = tbl[i].b;
            lift_done = tbl[i].d;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d", i), tbl[i].req, tbl[i].qe, tbl[i].lamp, tbl[i].served);
        end

        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [5:0] b;
            for (int k = 0; k < 6; k++) b[k] = ($urandom_range(0, 4) == 0);
            drive(b, ($urandom_range(0, 2) == 0), $sformatf("rand%0d", i));
        end

        // four entries queued, then reset asserted between edges
        do_reset();
        drive(6'b001111, 1'b0, "rst_seq_press");
        for (int i = 0; i < 4; i++) drive(6'b000000, 1'b0, $sformatf("rst_seq_load%0d", i));
        #1;
        rst = 1'b1;
        #1;
        check("async_rst", 3'b000, 1'b1, 6'b0, 6'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(6'b000000, 1'b1, "no_pop_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
